// File: rtl/if_fetcher_pkg.sv
// Shared widths and FSM encoding for the instruction fetcher.
package if_fetcher_pkg;

    localparam int addrWidth    = 32;
    localparam int instWidth    = 32;
    localparam int memDataWidth = 8;

    // Two-bit state encoding of the fetch FSM
    typedef enum logic [1:0] {
        IF_IDLE  = 2'b00,
        IF_ISSUE = 2'b01,
        IF_WAIT  = 2'b10,
        IF_HOLD  = 2'b11
    } fetchState_e;

endpackage

// File: rtl/if_fetcher_if.sv
// Bundle of PC-unit, byte-wide memory port and IF/ID signals around the fetcher.
interface if_fetcher_if
    import if_fetcher_pkg::*;
#(
    parameter int ADDR_WIDTH     = addrWidth,
    parameter int INST_WIDTH     = instWidth,
    parameter int MEM_DATA_WIDTH = memDataWidth
) ();

    logic [ADDR_WIDTH-1:0]     PC;
    logic                      PC_stall;
    logic                      mem_req;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic                      mem_gnt;
    logic                      mem_rvalid;
    logic [MEM_DATA_WIDTH-1:0] mem_rdata;
    logic [INST_WIDTH-1:0]     inst;
    logic [ADDR_WIDTH-1:0]     inst_pc;
    logic                      inst_valid;
    logic                      id_stall;
    logic                      flush;

    modport master (
        input  PC,
        output PC_stall,
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata,
        output inst,
        output inst_pc,
        output inst_valid,
        input  id_stall,
        input  flush
    );

    modport slave (
        output PC,
        input  PC_stall,
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata,
        input  inst,
        input  inst_pc,
        input  inst_valid,
        output id_stall,
        output flush
    );

endinterface

// File: rtl/if_fetcher.sv
// Instruction fetcher: assembles one 32-bit instruction from four byte reads
// per PC value and holds the PC until decode accepts the instruction.
module if_fetcher
    import if_fetcher_pkg::*;
#(
    parameter int ADDR_WIDTH     = addrWidth,
    parameter int INST_WIDTH     = instWidth,
    // INST_WIDTH must be exactly four lanes of MEM_DATA_WIDTH
    parameter int MEM_DATA_WIDTH = memDataWidth
) (
    input  logic         clk,
    input  logic         rst,
    if_fetcher_if.master bus
);

    fetchState_e             state_q,   state_d;
    logic [1:0]              byteCnt_q, byteCnt_d;
    // Only the word address is kept; the byte offset comes from byteCnt
    logic [ADDR_WIDTH-3:0]   fetchPc_q, fetchPc_d;
    logic [INST_WIDTH-1:0]   inst_q,    inst_d;
    logic [ADDR_WIDTH-1:0]   instPc_q,  instPc_d;
    // Set when a flushed request still has a response in flight
    logic                    drain_q,   drain_d;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IF_IDLE;
            byteCnt_q <= '0;
            fetchPc_q <= '0;
            inst_q    <= '0;
            instPc_q  <= '0;
            drain_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            byteCnt_q <= byteCnt_d;
            fetchPc_q <= fetchPc_d;
            inst_q    <= inst_d;
            instPc_q  <= instPc_d;
            drain_q   <= drain_d;
        end
    end

    // Next-state logic: request sequencing, byte assembly and flush draining
    always_comb begin
        state_d   = state_q;
        byteCnt_d = byteCnt_q;
        fetchPc_d = fetchPc_q;
        inst_d    = inst_q;
        instPc_d  = instPc_q;
        drain_d   = drain_q;

        case (state_q)
            IF_IDLE: begin
                fetchPc_d = bus.PC[ADDR_WIDTH-1:2];
                byteCnt_d = 2'd0;
                drain_d   = 1'b0;
                state_d   = bus.flush ? IF_IDLE : IF_ISSUE;
            end
            IF_ISSUE: begin
                if (bus.mem_gnt) begin
                    state_d = IF_WAIT;
                    if (bus.flush) begin
                        drain_d = 1'b1;
                    end
                end else if (bus.flush) begin
                    state_d = IF_IDLE;
                end
            end
            IF_WAIT: begin
                if (bus.mem_rvalid) begin
                    if (drain_q || bus.flush) begin
                        drain_d = 1'b0;
                        state_d = IF_IDLE;
                    end else begin
                        inst_d[byteCnt_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = bus.mem_rdata;
                        if (byteCnt_q == 2'd3) begin
                            instPc_d = {fetchPc_q, 2'b00};
                            state_d  = IF_HOLD;
                        end else begin
                            byteCnt_d = byteCnt_q + 2'd1;
                            state_d   = IF_ISSUE;
                        end
                    end
                end else if (bus.flush) begin
                    drain_d = 1'b1;
                end
            end
            IF_HOLD: begin
                if (bus.flush || !bus.id_stall) begin
                    state_d = IF_IDLE;
                end
            end
            default: begin
                state_d = IF_IDLE;
            end
        endcase
    end

    // A flush in HOLD suppresses the handoff, so the PC never advances for it
    assign bus.PC_stall   = ~((state_q == IF_HOLD) && !bus.id_stall && !bus.flush);
    assign bus.mem_req    = (state_q == IF_ISSUE);
    assign bus.mem_addr   = (state_q == IF_ISSUE) ? {fetchPc_q, byteCnt_q} : '0;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = instPc_q;
    assign bus.inst_valid = (state_q == IF_HOLD);

endmodule

// File: tb/tb_if_fetcher.sv
// Directed bench for if_fetcher with a byte memory model and a PC-unit model.
module tb_if_fetcher;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;
    int   cyc;

    logic [31:0] respDelayAddr;
    int          respDelayCycles;
    logic [31:0] gntHoldAddr;
    int          gntHoldCycles;

    if_fetcher_if #(.ADDR_WIDTH(32), .INST_WIDTH(32), .MEM_DATA_WIDTH(8)) bus ();

    if_fetcher #(.ADDR_WIDTH(32), .INST_WIDTH(32), .MEM_DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: grant on request (optionally withheld), one in-order response per grant
    initial begin
        logic [7:0]  memArr [0:255];
        logic        respPending;
        int          respCnt;
        logic [7:0]  respData;
        int          holdCnt;
        logic [7:0]  idx;
        for (int i = 0; i < 256; i++) memArr[i] = 8'h00;
        memArr[0]  = 8'h13; memArr[1]  = 8'h05; memArr[2]  = 8'h10; memArr[3]  = 8'h00;
        memArr[4]  = 8'h93; memArr[5]  = 8'h01; memArr[6]  = 8'h20; memArr[7]  = 8'h00;
        memArr[8]  = 8'hEF; memArr[9]  = 8'hBE; memArr[10] = 8'hAD; memArr[11] = 8'hDE;
        memArr[16] = 8'hB7; memArr[17] = 8'h42; memArr[18] = 8'h13; memArr[19] = 8'h00;
        respPending    = 1'b0;
        respCnt        = 0;
        respData       = 8'h00;
        holdCnt        = 0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            bus.mem_rvalid = 1'b0;
            if (respPending) begin
                if (respCnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = respData;
                    respPending    = 1'b0;
                end else begin
                    respCnt--;
                end
            end
            bus.mem_gnt = 1'b0;
            if (bus.mem_req === 1'b1) begin
                if (bus.mem_addr == gntHoldAddr && holdCnt < gntHoldCycles) begin
                    holdCnt++;
                end else begin
                    bus.mem_gnt = 1'b1;
                    holdCnt     = 0;
                    idx         = bus.mem_addr[7:0];
                    respPending = 1'b1;
                    respData    = memArr[idx];
                    respCnt     = (bus.mem_addr == respDelayAddr) ? respDelayCycles : 0;
                end
            end else begin
                holdCnt = 0;
            end
        end
    end

    // Advance one cycle; the PC-unit model adds 4 when the previous cycle was a handoff
    task automatic step();
        logic adv;
        adv = (bus.PC_stall === 1'b0) && !rst;
        @(negedge clk);
        if (adv) bus.PC = bus.PC + 32'd4;
        cyc++;
    endtask

    // Hold reset for two edges, then release with the given PC; returns in the first IDLE cycle
    task automatic doReset(input logic [31:0] pc);
        step();
        rst          = 1'b1;
        bus.PC       = pc;
        bus.id_stall = 1'b0;
        bus.flush    = 1'b0;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        #2;
    endtask

    task automatic test_reset();
        step();
        rst = 1'b1;
        step();
        step();
        #2;
        testsRun++; if (bus.mem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        testsRun++; if (bus.mem_addr !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        testsRun++; if (bus.inst !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_inst: got %h want 0", bus.inst); end
        testsRun++; if (bus.inst_pc !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_inst_pc: got %h want 0", bus.inst_pc); end
        testsRun++; if (bus.inst_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_inst_valid: got %b want 0", bus.inst_valid); end
        testsRun++; if (bus.PC_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_pc_stall: got %b want 1", bus.PC_stall); end
    endtask

    task automatic test_basic_fetch();
        logic [31:0] addrs [0:7];
        int          nAddr;
        int          firstValid;
        int          stallLow;
        int          stallLowCyc;
        logic [31:0] gotInst;
        logic [31:0] gotPc;
        nAddr = 0; firstValid = -1; stallLow = 0; stallLowCyc = -1; gotInst = 'x; gotPc = 'x;
        doReset(32'h0);
        for (int c = 0; c <= 10; c++) begin
            if (bus.mem_req === 1'b1 && bus.mem_gnt === 1'b1 && nAddr < 8) begin
                addrs[nAddr] = bus.mem_addr;
                nAddr++;
            end
            if (bus.inst_valid === 1'b1 && firstValid < 0) begin
                firstValid = cyc;
                gotInst    = bus.inst;
                gotPc      = bus.inst_pc;
            end
            if (bus.PC_stall === 1'b0) begin
                stallLow++;
                stallLowCyc = cyc;
            end
            if (c < 10) begin
                step();
                #2;
            end
        end
        testsRun++; if (nAddr !== 4) begin testsFailed++; $display("[TB] FAIL basic_grant_count: got %0d want 4", nAddr); end
        for (int i = 0; i < 4 && i < nAddr; i++) begin
            testsRun++; if (addrs[i] !== i) begin testsFailed++; $display("[TB] FAIL basic_addr%0d: got %h want %h", i, addrs[i], i); end
        end
        testsRun++; if (firstValid !== 9) begin testsFailed++; $display("[TB] FAIL basic_valid_cycle: got %0d want 9", firstValid); end
        testsRun++; if (gotInst !== 32'h00100513) begin testsFailed++; $display("[TB] FAIL basic_inst: got %h want 00100513", gotInst); end
        testsRun++; if (gotPc !== 32'h0) begin testsFailed++; $display("[TB] FAIL basic_inst_pc: got %h want 0", gotPc); end
        testsRun++; if (stallLow !== 1 || stallLowCyc !== 9) begin testsFailed++; $display("[TB] FAIL basic_pc_stall_low: got %0d cycles (last %0d) want 1 at 9", stallLow, stallLowCyc); end
        testsRun++; if (bus.inst_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_valid_clear: got %b want 0", bus.inst_valid); end
    endtask

    task automatic test_gnt_wait();
        int reqAt2;
        int firstAt2;
        int grantAt2;
        int waited;
        reqAt2 = 0; firstAt2 = -1; grantAt2 = -1; waited = 0;
        gntHoldAddr   = 32'h2;
        gntHoldCycles = 3;
        doReset(32'h0);
        while (bus.inst_valid !== 1'b1 && waited < 40) begin
            if (bus.mem_req === 1'b1 && bus.mem_addr === 32'h2) begin
                reqAt2++;
                if (firstAt2 < 0) firstAt2 = cyc;
                if (bus.mem_gnt === 1'b1) grantAt2 = cyc;
            end
            step();
            #2;
            waited++;
        end
        gntHoldAddr   = 32'hFFFF_FFFF;
        gntHoldCycles = 0;
        testsRun++; if (bus.inst_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL gnt_timeout: inst_valid=%b after %0d cycles want 1", bus.inst_valid, waited); end
        testsRun++; if (reqAt2 !== 4) begin testsFailed++; $display("[TB] FAIL gnt_req_cycles: got %0d want 4", reqAt2); end
        testsRun++; if (firstAt2 !== 5 || grantAt2 !== 8) begin testsFailed++; $display("[TB] FAIL gnt_window: got %0d..%0d want 5..8", firstAt2, grantAt2); end
        testsRun++; if (cyc !== 12) begin testsFailed++; $display("[TB] FAIL gnt_valid_cycle: got %0d want 12", cyc); end
        testsRun++; if (bus.inst !== 32'h00100513) begin testsFailed++; $display("[TB] FAIL gnt_inst: got %h want 00100513", bus.inst); end
    endtask

    task automatic test_id_stall();
        logic [31:0] addrs [0:7];
        int          nAddr;
        int          waited;
        nAddr = 0; waited = 0;
        doReset(32'h0);
        bus.id_stall = 1'b1;
        #2;
        while (bus.inst_valid !== 1'b1 && waited < 40) begin
            step();
            #2;
            waited++;
        end
        testsRun++; if (bus.inst_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_timeout: inst_valid=%b want 1", bus.inst_valid); end
        for (int i = 0; i < 5; i++) begin
            step();
            #2;
            testsRun++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h00100513 || bus.inst_pc !== 32'h0) begin
                testsFailed++; $display("[TB] FAIL stall_hold%0d: valid=%b inst=%h pc=%h want 1/00100513/0", i, bus.inst_valid, bus.inst, bus.inst_pc);
            end
            testsRun++; if (bus.PC_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_pc_stall%0d: got %b want 1", i, bus.PC_stall); end
        end
        step();
        bus.id_stall = 1'b0;
        #2;
        testsRun++; if (bus.PC_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_release: PC_stall=%b want 0", bus.PC_stall); end
        step();
        bus.id_stall = 1'b1;
        #2;
        testsRun++; if (bus.inst_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_valid_clear: got %b want 0", bus.inst_valid); end
        testsRun++; if (bus.PC !== 32'h4) begin testsFailed++; $display("[TB] FAIL stall_pc_adv: PC=%h want 4", bus.PC); end
        waited = 0;
        while (bus.inst_valid !== 1'b1 && waited < 40) begin
            if (bus.mem_req === 1'b1 && bus.mem_gnt === 1'b1 && nAddr < 8) begin
                addrs[nAddr] = bus.mem_addr;
                nAddr++;
            end
            step();
            #2;
            waited++;
        end
        testsRun++; if (nAddr !== 4) begin testsFailed++; $display("[TB] FAIL stall_next_count: got %0d grants want 4", nAddr); end
        for (int i = 0; i < 4 && i < nAddr; i++) begin
            testsRun++; if (addrs[i] !== 32'h4 + i) begin testsFailed++; $display("[TB] FAIL stall_next_addr%0d: got %h want %h", i, addrs[i], 32'h4 + i); end
        end
        testsRun++; if (bus.inst !== 32'h00200193 || bus.inst_pc !== 32'h4) begin
            testsFailed++; $display("[TB] FAIL stall_next_inst: inst=%h pc=%h want 00200193/4", bus.inst, bus.inst_pc);
        end
    endtask

    task automatic test_flush_wait();
        int waited;
        waited = 0;
        respDelayAddr   = 32'h9;
        respDelayCycles = 2;
        doReset(32'h8);
        while (!(bus.mem_req === 1'b1 && bus.mem_gnt === 1'b1 && bus.mem_addr === 32'h9) && waited < 20) begin
            step();
            #2;
            waited++;
        end
        testsRun++; if (bus.mem_addr !== 32'h9) begin testsFailed++; $display("[TB] FAIL flush_find_byte1: mem_addr=%h want 9", bus.mem_addr); end
        step();
        bus.flush = 1'b1;
        #2;
        testsRun++; if (bus.PC_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_pc_stall: got %b want 1", bus.PC_stall); end
        step();
        bus.flush     = 1'b0;
        respDelayAddr = 32'hFFFF_FFFF;
        #2;
        for (int i = 0; i < 3; i++) begin
            testsRun++; if (bus.inst_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
                testsFailed++; $display("[TB] FAIL flush_drain%0d: valid=%b req=%b want 0/0", i, bus.inst_valid, bus.mem_req);
            end
            step();
            #2;
        end
        testsRun++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8) begin
            testsFailed++; $display("[TB] FAIL flush_restart: req=%b addr=%h want 1/8", bus.mem_req, bus.mem_addr);
        end
        waited = 0;
        while (bus.inst_valid !== 1'b1 && waited < 40) begin
            step();
            #2;
            waited++;
        end
        testsRun++; if (bus.inst !== 32'hDEADBEEF || bus.inst_pc !== 32'h8) begin
            testsFailed++; $display("[TB] FAIL flush_refetch: inst=%h pc=%h want deadbeef/8", bus.inst, bus.inst_pc);
        end
    endtask

    task automatic test_flush_handoff();
        int waited;
        waited = 0;
        doReset(32'h0);
        bus.id_stall = 1'b1;
        #2;
        while (bus.inst_valid !== 1'b1 && waited < 40) begin
            step();
            #2;
            waited++;
        end
        step();
        bus.id_stall = 1'b0;
        bus.flush    = 1'b1;
        #2;
        testsRun++; if (bus.PC_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL fh_pc_stall: got %b want 1", bus.PC_stall); end
        testsRun++; if (bus.inst_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL fh_valid_same: got %b want 1", bus.inst_valid); end
        step();
        bus.flush    = 1'b0;
        bus.id_stall = 1'b1;
        #2;
        testsRun++; if (bus.inst_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL fh_valid_next: got %b want 0", bus.inst_valid); end
        testsRun++; if (bus.PC !== 32'h0) begin testsFailed++; $display("[TB] FAIL fh_pc_held: PC=%h want 0", bus.PC); end
        step();
        #2;
        testsRun++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
            testsFailed++; $display("[TB] FAIL fh_refetch: req=%b addr=%h want 1/0", bus.mem_req, bus.mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        waited = 0;
        respDelayAddr   = 32'h12;
        respDelayCycles = 2;
        doReset(32'h10);
        while (!(bus.mem_req === 1'b1 && bus.mem_gnt === 1'b1 && bus.mem_addr === 32'h12) && waited < 20) begin
            step();
            #2;
            waited++;
        end
        step();
        rst = 1'b1;
        #2;
        step();
        rst           = 1'b0;
        respDelayAddr = 32'hFFFF_FFFF;
        #2;
        testsRun++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
            testsFailed++; $display("[TB] FAIL rm_mem: req=%b addr=%h want 0/0", bus.mem_req, bus.mem_addr);
        end
        testsRun++; if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0 || bus.inst_valid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL rm_inst: inst=%h pc=%h valid=%b want 0/0/0", bus.inst, bus.inst_pc, bus.inst_valid);
        end
        testsRun++; if (bus.PC_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL rm_pc_stall: got %b want 1", bus.PC_stall); end
        step();
        #2;
        testsRun++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10) begin
            testsFailed++; $display("[TB] FAIL rm_restart: req=%b addr=%h want 1/10", bus.mem_req, bus.mem_addr);
        end
        waited = 0;
        while (bus.inst_valid !== 1'b1 && waited < 40) begin
            step();
            #2;
            waited++;
        end
        testsRun++; if (bus.inst !== 32'h001342B7 || bus.inst_pc !== 32'h10) begin
            testsFailed++; $display("[TB] FAIL rm_refetch: inst=%h pc=%h want 001342b7/10", bus.inst, bus.inst_pc);
        end
    endtask

    // Test sequence
    initial begin
        testsRun        = 0;
        testsFailed     = 0;
        cyc             = 0;
        rst             = 1'b1;
        bus.PC          = 32'h0;
        bus.id_stall    = 1'b0;
        bus.flush       = 1'b0;
        respDelayAddr   = 32'hFFFF_FFFF;
        respDelayCycles = 0;
        gntHoldAddr     = 32'hFFFF_FFFF;
        gntHoldCycles   = 0;
        test_reset();
        test_basic_fetch();
        test_gnt_wait();
        test_id_stall();
        test_flush_wait();
        test_flush_handoff();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Watchdog against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", testsRun);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
